// File: rtl/probe_capture_fifo.sv
// Multi-channel signal probe: samples NUM_CH channels, tags each capture
// with a timestamp and change mask, and buffers records in a FIFO.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en, mode    capture enable; 0 = periodic, 1 = on change
//   period      periodic mode captures every period+1 cycles
//   ch_data     channel i at [i*DATA_W +: DATA_W]
//   out_*       registered FIFO head, valid/ready drained
//   level       FIFO occupancy, 0..DEPTH
//   drop_cnt    captures lost to a full FIFO, saturating
//
// Macro PROBE_CAPTURE_TS_EN: timestamp counter and per-entry storage;
// when undefined out_ts is tied to 0.
module probe_capture_fifo #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [15:0]              period,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [NUM_CH-1:0]        out_chg,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = NUM_CH * DATA_W;

  logic [CW-1:0]     r_prev;
  logic [15:0]       r_div;
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [15:0]       r_drop;
  logic [CW-1:0]     r_mem_data [DEPTH];
  logic [NUM_CH-1:0] r_mem_chg  [DEPTH];

  logic [NUM_CH-1:0] w_chg;
  logic              w_div_hit;
  logic              w_cap;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AW-1:0]     w_wa;
  logic [AW-1:0]     w_ra;

  always_comb begin
    w_chg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_chg[i] = ch_data[i*DATA_W +: DATA_W]
              != r_prev[i*DATA_W +: DATA_W];
    end
  end

  assign w_div_hit = (r_div == period);
  assign w_cap = en & ((~mode & w_div_hit)
                     | (mode & (|w_chg)));

  assign w_wa    = r_wptr[AW-1:0];
  assign w_ra    = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  // Same slot, opposite lap bit: writer is one full lap ahead.
  assign w_full  = (r_wptr[AW] != r_rptr[AW])
                && (w_wa == w_ra);

  assign w_pop  = ~w_empty & out_ready;
  // When full, a same-cycle pop frees the head slot for the push.
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  assign out_valid = ~w_empty;
  assign level     = r_wptr - r_rptr;
  assign drop_cnt  = r_drop;
  assign out_data  = out_valid ? r_mem_data[w_ra] : '0;
  assign out_chg   = out_valid ? r_mem_chg[w_ra] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_div  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_drop <= '0;
    end else begin
      r_prev <= ch_data;
      if (!en || mode || w_div_hit) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 16'd1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop && r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  // Storage needs no reset: empty entries are masked on the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[w_wa] <= ch_data;
      r_mem_chg[w_wa]  <= w_chg;
    end
  end

`ifdef PROBE_CAPTURE_TS_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_ts [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ts[w_wa] <= r_ts;
    end
  end

  assign out_ts = out_valid ? r_mem_ts[w_ra] : '0;
`else
  assign out_ts = '0;
`endif

endmodule

// File: tb/tb_probe_capture_fifo.sv
// Self-checking bench for probe_capture_fifo: directed scenarios plus
// randomized traffic compared against a queue-based record model.
module tb_probe_capture_fifo;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 32;
  localparam int CW     = NUM_CH * DATA_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            mode;
  logic [15:0]     period;
  logic [CW-1:0]   ch_data;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_data;
  logic [TS_W-1:0] out_ts;
  logic [NUM_CH-1:0] out_chg;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]     drop_cnt;

  probe_capture_fifo #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .period   (period),
    .ch_data  (ch_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ts   (out_ts),
    .out_chg  (out_chg),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]     d;
    logic [TS_W-1:0]   ts;
    logic [NUM_CH-1:0] chg;
  } rec_t;

  rec_t          q[$];
  logic [TS_W-1:0] m_ts;
  logic [CW-1:0] m_prev;
  int            m_div;
  int            m_drop;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ts   = '0;
    m_prev = '0;
    m_div  = 0;
    m_drop = 0;
  endtask

  task automatic check_outputs();
    rec_t h;
    bit   v;
    v = (q.size() != 0);
    h.d = '0;
    h.ts = '0;
    h.chg = '0;
    if (v) h = q[0];
`ifndef PROBE_CAPTURE_TS_EN
    h.ts = '0;
`endif
    chk("valid", 64'(out_valid), 64'(v));
    chk("level", 64'(level), 64'(q.size()));
    chk("drop", 64'(drop_cnt), 64'(m_drop));
    chk("data", 64'(out_data), 64'(h.d));
    chk("ts", 64'(out_ts), 64'(h.ts));
    chk("chg", 64'(out_chg), 64'(h.chg));
  endtask

  // One clock: decide from the rules what happens at the edge,
  // then apply it to the record queue and compare.
  task automatic step();
    logic [NUM_CH-1:0] c;
    logic [CW-1:0]     d;
    bit cap, pop, e, m;
    rec_t r;
    d = ch_data;
    e = en;
    m = mode;
    for (int i = 0; i < NUM_CH; i++)
      c[i] = d[i*DATA_W +: DATA_W]
          != m_prev[i*DATA_W +: DATA_W];
    cap = e && (m ? (c != 0) : (m_div == int'(period)));
    pop = (q.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) begin
        r.d = d;
        r.ts = m_ts;
        r.chg = c;
        q.push_back(r);
      end else if (m_drop < 16'hFFFF) begin
        m_drop++;
      end
    end
    m_ts   = m_ts + 1'b1;
    m_prev = d;
    m_div  = (!e || m || cap) ? 0 : m_div + 1;
    check_outputs();
  endtask

  // Reset lands mid-cycle; outputs must clear before the next edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    rst_n     = 1'b1;
    en        = 1'b0;
    mode      = 1'b0;
    period    = '0;
    ch_data   = '0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();

    // Periodic capture, period 3
    en        = 1'b1;
    period    = 16'd3;
    out_ready = 1'b1;
    ch_data   = 64'h1111_2222_3333_4444;
    repeat (16) step();

    // Capture on change, single channel
    mode = 1'b1;
    repeat (3) step();
    chk("chg_idle", 64'(out_valid), 64'd0);
    ch_data[2*DATA_W +: DATA_W] = 16'hABCD;
    step();
    chk("chg_mask", 64'(out_chg), 64'b0100);
    chk("chg_d2", 64'(out_data[2*DATA_W +: DATA_W]),
        64'hABCD);
    step();
    chk("chg_once", 64'(out_valid), 64'd0);

    // Hold head under back-pressure
    mode      = 1'b0;
    period    = 16'd0;
    out_ready = 1'b0;
    repeat (2) step();
    en = 1'b0;
    ch_data = 64'h0BAD_F00D_1234_5678;
    repeat (5) step();

    // Build level 5 / drop 2, then reset mid-cycle
    apply_reset();
    en = 1'b1;
    repeat (10) step();
    chk("pre_drop", 64'(drop_cnt), 64'd2);
    en        = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("pre_level", 64'(level), 64'd5);
    apply_reset();

    // Overfill from reset: 8 kept, 4 dropped
    en        = 1'b1;
    out_ready = 1'b0;
    repeat (12) step();
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_drop", 64'(drop_cnt), 64'd4);

    // Full with simultaneous pop: no drops
    out_ready = 1'b1;
    repeat (6) step();
    chk("full_level", 64'(level), 64'd8);
    chk("full_drop", 64'(drop_cnt), 64'd4);
    en = 1'b0;
    repeat (10) step();

    // Randomized traffic
    for (int p = 0; p < 15; p++) begin
      en     = ($urandom_range(0, 3) != 0);
      mode   = 1'($urandom_range(0, 1));
      period = 16'($urandom_range(0, 5));
      for (int k = 0; k < 20; k++) begin
        out_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0)
          ch_data[$urandom_range(0, NUM_CH-1)*DATA_W +: DATA_W]
            = 16'($urandom);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
